// File: rtl/muldiv_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit; also used by the
// decoder and the hazard unit.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/exe_muldiv.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on magnitudes, sign fix-up in a final cycle.
module exe_muldiv
    import muldiv_pkg::*;
#(
    parameter int ITER = muldiv_pkg::ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] LAST = 6'(ITER - 1);

    function automatic logic [31:0] f_abs(input logic [31:0] v, input logic is_signed);
        logic signed [31:0] s;
        s = v;
        return (is_signed && s < 0) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] f_neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [31:0] f_neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    state_e      r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_sr;
    logic [31:0] r_dvs;
    logic [31:0] r_a_raw;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    op_e         w_op;
    logic        w_signed;
    logic [63:0] w_mul_next;
    logic [63:0] w_div_shift;
    logic        w_div_ge;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_op     = op_e'(op);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

    // Multiply consumes the multiplier MSB-first, so the accumulator shifts left.
    assign w_mul_next  = {r_acc[62:0], 1'b0} + (r_sr[31] ? {32'd0, r_dvs} : 64'd0);
    assign w_div_shift = {r_acc[62:0], r_sr[31]};
    assign w_div_ge    = (w_div_shift >= {32'd0, r_dvs});
    assign w_div_next  = w_div_ge ? (w_div_shift - {32'd0, r_dvs}) : w_div_shift;

    assign w_prod = r_neg_q ? f_neg64(r_acc) : r_acc;
    assign w_quot = r_neg_q ? f_neg32(r_sr) : r_sr;
    assign w_rem  = r_neg_r ? f_neg32(r_acc[31:0]) : r_acc[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_sr     <= f_abs(a, w_signed);
                        r_dvs    <= f_abs(b, w_signed);
                        r_a_raw  <= a;
                        r_acc    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed && (a[31] ^ b[31]);
                        r_neg_r  <= w_signed && a[31];
                        r_dz     <= op[1] && (b == 32'd0);
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc <= w_div_next;
                            r_sr  <= {r_sr[30:0], w_div_ge};
                        end else begin
                            r_acc <= w_mul_next;
                            r_sr  <= {r_sr[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_done <= 1'b1;
                        // Divide by zero reports the raw dividend, unaffected by sign fix-up.
                        if (!r_is_div) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_dz) begin
                            r_hi <= r_a_raw;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall = (r_state != S_IDLE);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
